spi_mem_target: RTL and testbench

Synthesizable SPI memory responder: the target end of the SPI flash/RAM link driven by the SoC's SPI memory initiator. It oversamples `spi_sclk`/`spi_cs_n`/`spi_mosi` in the `clk` domain and decodes mode-0, MSB-first READ (0x03) and WRITE (0x02) transactions with a 24-bit address. It serves a local byte array and drives `spi_miso`. It is used as an on-FPGA flash/PSRAM stand-in and as a bench target, with a backdoor port for image preload and inspection.

---
 rtl/spi_mem_target_if.sv | 22 ++
 rtl/spi_mem_target.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_mem_target.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_target_if.sv
// spi_mem_target_if: SPI pin bundle between memory initiator and target.
// The initiator drives select, clock and MOSI; the target drives MISO.
interface spi_mem_target_if;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_cs_n,
    output spi_sclk,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_cs_n,
    input  spi_sclk,
    input  spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/spi_mem_target.sv
// spi_mem_target: mode-0 SPI READ/WRITE memory target with backdoor port.
// Define SPI_MEM_TARGET_FAST_READ_EN to accept FAST READ (0x0B).
module spi_mem_target #(
  parameter int DEPTH = 8192,
  parameter int AW    = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_mem_target_if.slave spi,
  output logic            active,
  input  logic            bd_we,
  input  logic [AW-1:0]   bd_addr,
  input  logic [7:0]      bd_wdata,
  output logic [7:0]      bd_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_READ,
    S_WRITE,
    S_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    K_RD,
    K_WR,
    K_FR
  } kind_t;

  state_t state, nxt;
  kind_t  kind;

  logic          cs_s1, cs_s2, cs_d;
  logic          sclk_s1, sclk_s2, sclk_d;
  logic          mosi_s1, mosi_s2;
  logic          rise, fall, cs_fall;
  logic [2:0]    bcnt;
  logic [1:0]    acnt;
  logic [6:0]    sh;
  logic [7:0]    sh_nxt;
  logic [7:0]    tx;
  logic          miso_q;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_sh;
  logic [AW-1:0] ptr_inc;
  logic          last_bit;
  logic          addr_done;
  logic          cmd_rd, cmd_wr, cmd_fr;
  logic          spi_we;

  logic [7:0] mem [DEPTH];

  // CS flops reset to "selected" so a select held low through reset
  // yields no falling edge: we wait for a fresh CS assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_d    <= 1'b0;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= spi.spi_cs_n;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sclk_s1 <= spi.spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= spi.spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign rise    = sclk_s2 & ~sclk_d & ~cs_s2;
  assign fall    = ~sclk_s2 & sclk_d & ~cs_s2;
  assign cs_fall = cs_d & ~cs_s2;

  assign sh_nxt    = {sh, mosi_s2};
  assign ptr_sh    = {ptr[AW-2:0], mosi_s2};
  assign ptr_inc   = ptr + 1'b1;
  assign last_bit  = (bcnt == 3'd7);
  assign addr_done = last_bit & (acnt == 2'd2);
  assign spi_we    = (state == S_WRITE) & rise & last_bit;

  always_comb begin
    cmd_rd = (sh_nxt == 8'h03);
    cmd_wr = (sh_nxt == 8'h02);
`ifdef SPI_MEM_TARGET_FAST_READ_EN
    cmd_fr = (sh_nxt == 8'h0B);
`else
    cmd_fr = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (cs_s2) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (cs_fall) nxt = S_CMD;
        S_CMD: begin
          if (rise && last_bit) begin
            if (cmd_rd | cmd_wr | cmd_fr) nxt = S_ADDR;
            else                          nxt = S_IGNORE;
          end
        end
        S_ADDR: begin
          if (rise && addr_done) begin
            unique case (kind)
              K_WR:    nxt = S_WRITE;
              K_FR:    nxt = S_DUMMY;
              default: nxt = S_READ;
            endcase
          end
        end
        S_DUMMY: if (rise && last_bit) nxt = S_READ;
        default: nxt = state;
      endcase
    end
  end

  always_comb begin
    active = (state == S_READ) |
             (state == S_WRITE) |
             (state == S_DUMMY);
  end

  assign spi.spi_miso = miso_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt   <= 3'd0;
      acnt   <= 2'd0;
      sh     <= 7'd0;
      tx     <= 8'd0;
      ptr    <= '0;
      kind   <= K_RD;
      miso_q <= 1'b0;
    end else begin
      if (state != S_READ || cs_s2) miso_q <= 1'b0;
      else if (fall)                miso_q <= tx[7];
      unique case (state)
        S_IDLE: begin
          bcnt <= 3'd0;
          acnt <= 2'd0;
        end
        S_CMD: begin
          if (rise) begin
            sh   <= sh_nxt[6:0];
            bcnt <= bcnt + 3'd1;
            if (last_bit) begin
              unique case (1'b1)
                cmd_wr:  kind <= K_WR;
                cmd_fr:  kind <= K_FR;
                default: kind <= K_RD;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            ptr  <= ptr_sh;
            bcnt <= bcnt + 3'd1;
            if (last_bit) acnt <= acnt + 2'd1;
            if (addr_done) tx <= mem[ptr_sh];
          end
        end
        S_DUMMY: begin
          if (rise) begin
            bcnt <= bcnt + 3'd1;
            if (last_bit) tx <= mem[ptr];
          end
        end
        S_READ: begin
          if (fall) begin
            bcnt <= bcnt + 3'd1;
            if (last_bit) begin
              ptr <= ptr_inc;
              tx  <= mem[ptr_inc];
            end else begin
              tx  <= {tx[6:0], 1'b0};
            end
          end
        end
        S_WRITE: begin
          if (rise) begin
            sh   <= sh_nxt[6:0];
            bcnt <= bcnt + 3'd1;
            if (last_bit) ptr <= ptr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // SPI write is issued last so it wins a same-address backdoor collision.
  always_ff @(posedge clk) begin
    if (bd_we)  mem[bd_addr] <= bd_wdata;
    if (spi_we) mem[ptr]     <= sh_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bd_rdata <= 8'd0;
    else        bd_rdata <= mem[bd_addr];
  end

endmodule

// File: tb/tb_spi_mem_target.sv
// tb_spi_mem_target: directed SPI READ/WRITE/IGNORE/wrap/reset checks
// against spi_mem_target with hand-computed expected bytes.
module tb_spi_mem_target;

  localparam int HALF = 6;

  logic        clk;
  logic        rst_n;
  logic        active;
  logic        bd_we;
  logic [12:0] bd_addr;
  logic [7:0]  bd_wdata;
  logic [7:0]  bd_rdata;

  int passed;
  int total;
  logic act_and;
  logic act_or;
  logic [7:0] rx;

  spi_mem_target_if spi ();

  spi_mem_target #(
    .DEPTH(8192),
    .AW   (13)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi     (spi),
    .active  (active),
    .bd_we   (bd_we),
    .bd_addr (bd_addr),
    .bd_wdata(bd_wdata),
    .bd_rdata(bd_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic xfer(input logic [7:0] dout, input int nbits,
                      output logic [7:0] din);
    din = 8'd0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi.spi_mosi = dout[i];
      repeat (HALF) @(negedge clk);
      din     = {din[6:0], spi.spi_miso};
      act_and = act_and & active;
      act_or  = act_or | active;
      spi.spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    spi.spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic start(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] d;
    cs_begin();
    xfer(cmd, 8, d);
    xfer(a[23:16], 8, d);
    xfer(a[15:8], 8, d);
    xfer(a[7:0], 8, d);
    act_and = 1'b1;
    act_or  = 1'b0;
  endtask

  task automatic bd_write(input logic [12:0] a, input logic [7:0] d);
    bd_addr  = a;
    bd_wdata = d;
    bd_we    = 1'b1;
    @(negedge clk);
    bd_we    = 1'b0;
  endtask

  task automatic bd_check(input string tag, input logic [12:0] a,
                          input logic [7:0] exp);
    bd_addr = a;
    @(negedge clk);
    @(negedge clk);
    chk(tag, bd_rdata, exp);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    act_and = 1'b1;
    act_or  = 1'b0;
    rst_n = 1'b0;
    spi.spi_cs_n = 1'b1;
    spi.spi_sclk = 1'b0;
    spi.spi_mosi = 1'b0;
    bd_we    = 1'b0;
    bd_addr  = 13'd0;
    bd_wdata = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_miso", {7'd0, spi.spi_miso}, 8'd0);
    chk("rst_active", {7'd0, active}, 8'd0);
    chk("rst_bd_rdata", bd_rdata, 8'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    bd_write(13'h10, 8'h11);
    bd_write(13'h11, 8'h22);
    bd_write(13'h12, 8'h33);
    bd_write(13'h13, 8'h44);
    bd_write(13'h40, 8'h77);

    start(8'h03, 24'h000010);
    xfer(8'h00, 8, rx); chk("rd_b0", rx, 8'h11);
    xfer(8'h00, 8, rx); chk("rd_b1", rx, 8'h22);
    xfer(8'h00, 8, rx); chk("rd_b2", rx, 8'h33);
    xfer(8'h00, 8, rx); chk("rd_b3", rx, 8'h44);
    chk("rd_active", {7'd0, act_and}, 8'd1);
    cs_end();
    chk("miso_after_cs", {7'd0, spi.spi_miso}, 8'd0);

    start(8'h02, 24'h000020);
    xfer(8'hA5, 8, rx);
    xfer(8'h5A, 8, rx);
    chk("wr_active", {7'd0, act_and}, 8'd1);
    cs_end();
    bd_check("wr_20", 13'h20, 8'hA5);
    bd_check("wr_21", 13'h21, 8'h5A);

    start(8'h02, 24'h001FFF);
    xfer(8'h01, 8, rx);
    xfer(8'h02, 8, rx);
    cs_end();
    bd_check("wrap_1fff", 13'h1FFF, 8'h01);
    bd_check("wrap_0000", 13'h0000, 8'h02);
    start(8'h03, 24'h001FFF);
    xfer(8'h00, 8, rx); chk("wrap_rd0", rx, 8'h01);
    xfer(8'h00, 8, rx); chk("wrap_rd1", rx, 8'h02);
    cs_end();

    start(8'h02, 24'h000040);
    xfer(8'hC3, 5, rx);
    cs_end();
    bd_check("partial_40", 13'h40, 8'h77);
    start(8'h03, 24'h000010);
    xfer(8'h00, 8, rx); chk("after_partial", rx, 8'h11);
    cs_end();

    cs_begin();
    xfer(8'h9F, 8, rx);
    act_or = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xfer(8'hFF, 8, rx);
      chk($sformatf("ign_b%0d", i), rx, 8'h00);
    end
    chk("ign_active", {7'd0, act_or}, 8'd0);
    cs_end();
    start(8'h03, 24'h000012);
    xfer(8'h00, 8, rx); chk("after_ign", rx, 8'h33);
    cs_end();

    start(8'h0B, 24'h000010);
    xfer(8'h00, 8, rx);
`ifdef SPI_MEM_TARGET_FAST_READ_EN
    xfer(8'h00, 8, rx); chk("fast_b0", rx, 8'h11);
    xfer(8'h00, 8, rx); chk("fast_b1", rx, 8'h22);
`else
    xfer(8'h00, 8, rx); chk("fast_b0", rx, 8'h00);
    xfer(8'h00, 8, rx); chk("fast_b1", rx, 8'h00);
`endif
    cs_end();

    start(8'h03, 24'h000010);
    xfer(8'h00, 4, rx);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    act_or = 1'b0;
    xfer(8'h00, 8, rx); chk("mrst_b0", rx, 8'h00);
    xfer(8'h00, 8, rx); chk("mrst_b1", rx, 8'h00);
    chk("mrst_active", {7'd0, act_or}, 8'd0);
    cs_end();
    start(8'h03, 24'h000013);
    xfer(8'h00, 8, rx); chk("after_mrst", rx, 8'h44);
    cs_end();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
